// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_STOP_BITS = 2;

  // Keeps an out-of-range character length from stalling the DATA state.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input int max_bits);
    if (int'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
    if (int'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Register-side signals of the receiver: line configuration in, queue head and status out.
interface uart_rx_cfg_if #(
  parameter int MAX_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 128,
  parameter int BAUD_W        = 13
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [BAUD_W-1:0]        baud_reload;
  logic [3:0]               data_bits;
  logic                     parity_en;
  logic                     parity_odd;
  logic                     two_stop;
  logic                     read_entry;
  logic                     clr_overrun;
  logic [MAX_DATA_BITS-1:0] rx_data;
  logic                     rx_parity_err;
  logic                     rx_frame_err;
  logic                     queue_empty;
  logic                     queue_full;
  logic [CNT_W-1:0]         num_entries;
  logic                     overrun;

  modport master (
    output baud_reload, data_bits, parity_en, parity_odd, two_stop, read_entry, clr_overrun,
    input  rx_data, rx_parity_err, rx_frame_err, queue_empty, queue_full, num_entries, overrun
  );

  modport slave (
    input  baud_reload, data_bits, parity_en, parity_odd, two_stop, read_entry, clr_overrun,
    output rx_data, rx_parity_err, rx_frame_err, queue_empty, queue_full, num_entries, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive queue; pointers carry one extra wrap bit so full and empty are distinct.
module uart_rx_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 128,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             accept,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [PTR_W-1:0] count
);
  localparam int AW = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == PTR_W'(DEPTH));
  assign accept  = !full || pop;
  assign do_push = push && accept;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers alone
  // define which entries are valid, so clearing the RAM would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time data length, parity and stop-bit selection feeding a receive queue.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 128,
  parameter int BAUD_W        = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RX,
  uart_rx_cfg_if.slave  bus
);
  localparam int ENTRY_W = MAX_DATA_BITS + 2;
  localparam int IDX_W   = $clog2(MAX_DATA_BITS);

  rx_state_t                state, state_nx;
  logic                     rx_meta, rx_s;
  logic [BAUD_W-1:0]        baud_cnt, baud_q;
  logic [3:0]               bits_q, bit_cnt, last_stop;
  logic                     par_en_q, par_odd_q, two_stop_q;
  logic [MAX_DATA_BITS-1:0] data_sr;
  logic                     parity_err, frame_err, overrun_q;
  logic                     sample, start_go, push, accept;
  logic [ENTRY_W-1:0]       head;

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  assign sample    = (state != IDLE) && (baud_cnt == '0);
  assign start_go  = (state == IDLE) && !rx_s;
  assign last_stop = two_stop_q ? 4'(MAX_STOP_BITS - 1) : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: defaults on every output before the case keep this block free of latches.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    unique case (state)
      IDLE:   if (!rx_s) state_nx = START;
      START:  if (sample) state_nx = rx_s ? IDLE : DATA;
      DATA:   if (sample && bit_cnt == bits_q - 4'd1) state_nx = par_en_q ? PARITY : STOP;
      PARITY: if (sample) state_nx = STOP;
      STOP: begin
        if (sample && bit_cnt == last_stop) begin
          push     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shadow config is captured once per frame so register writes mid-frame are harmless.
  always_ff @(posedge clk) begin
    if (start_go) begin
      baud_cnt   <= bus.baud_reload >> 1;
      baud_q     <= bus.baud_reload;
      bits_q     <= clamp_data_bits(bus.data_bits, MAX_DATA_BITS);
      par_en_q   <= bus.parity_en;
      par_odd_q  <= bus.parity_odd;
      two_stop_q <= bus.two_stop;
      data_sr    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (state != IDLE) begin
      baud_cnt <= sample ? baud_q : baud_cnt - BAUD_W'(1);
    end

    if (sample) begin
      case (state)
        START: bit_cnt <= '0;
        DATA: begin
          data_sr[bit_cnt[IDX_W-1:0]] <= rx_s;
          bit_cnt <= (state_nx == DATA) ? bit_cnt + 4'd1 : 4'd0;
        end
        PARITY: parity_err <= (^data_sr) ^ rx_s ^ par_odd_q;
        STOP: begin
          if (!rx_s) frame_err <= 1'b1;
          bit_cnt <= bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({frame_err | !rx_s, parity_err, data_sr}),
    .pop       (bus.read_entry),
    .accept    (accept),
    .head      (head),
    .empty     (bus.queue_empty),
    .full      (bus.queue_full),
    .count     (bus.num_entries)
  );

  always_ff @(posedge clk) begin
    if (rst)                  overrun_q <= 1'b0;
    else if (push && !accept) overrun_q <= 1'b1;
    else if (bus.clr_overrun) overrun_q <= 1'b0;
  end

  assign bus.overrun       = overrun_q;
  assign bus.rx_data       = head[MAX_DATA_BITS-1:0];
  assign bus.rx_parity_err = head[MAX_DATA_BITS];
  assign bus.rx_frame_err  = head[MAX_DATA_BITS+1];

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART receiver. It deserialises an asynchronous RX line with run-time selectable data length, parity and stop bits, and flags false starts, parity and framing errors. Each received character is pushed, together with its error status, into an internal circular receive queue of configurable depth. The block sits behind the memory-mapped UART register interface, next to the transmitter.

Parameters:
MAX_DATA_BITS, 8, widest character supported; legal range 5-9.
FIFO_DEPTH, 128, receive queue entries; must be a power of 2, minimum 2.
BAUD_W, 13, width of the baud reload value.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
RX  in  1  asynchronous serial input
baud_reload  in  BAUD_W  clocks per bit minus 1
data_bits  in  4  character length; 5 to MAX_DATA_BITS
parity_en  in  1  parity bit present
parity_odd  in  1  1 = odd parity, 0 = even parity
two_stop  in  1  two stop bits expected
read_entry  in  1  pop the head of the queue
clr_overrun  in  1  clear the sticky overrun flag
rx_data  out  MAX_DATA_BITS  head-of-queue character, right-justified, upper bits zero
rx_parity_err  out  1  parity error of the head entry
rx_frame_err  out  1  framing error of the head entry
queue_empty  out  1  queue holds no entries
queue_full  out  1  queue holds FIFO_DEPTH entries
num_entries  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
overrun  out  1  sticky; a character was dropped

Behaviour:
- Reset: clk and rst only; synchronous and active-high. On reset: state IDLE, both RX synchroniser flops = 1, pointers = 0, overrun = 0. Hence queue_empty=1, queue_full=0, num_entries=0. rx_data and the error outputs are don't-care while the queue is empty.
- Reset asserted mid-frame aborts the frame: nothing is pushed and no error is set.
- RX passes through two flops before use; rx_s is the second flop.
- Baud counter: loads baud_reload>>1 on entry to START and baud_reload after each sample. It decrements only outside IDLE. A sample event occurs when the counter is 0.
- Config inputs are sampled into shadow registers on the IDLE-to-START transition. Changes during a frame do not affect that frame.
- States:
  - IDLE -> START when rx_s == 0.
  - START: at the sample event, if rx_s == 1 it is a false start -> IDLE, no push. Otherwise -> DATA with bit counter = 0.
  - DATA: at each sample event, shift rx_s in LSB-first. After data_bits samples -> PARITY if parity_en, else STOP.
  - PARITY: compute XOR of the data bits and the parity sample. parity_err = XOR result XOR parity_odd... stated directly: an error when the total count of ones (data plus parity bit) is odd in even mode, or even in odd mode. Then -> STOP.
  - STOP: sample one stop bit, or two if two_stop. frame_err = 1 if any stop sample is 0. At the final stop sample, push and -> IDLE in the same cycle, so a start bit arriving back-to-back is caught.
- Push: the entry is {frame_err, parity_err, data}. It is accepted when !queue_full or read_entry is asserted in the same cycle. Otherwise the character is dropped and overrun is set.
- overrun clears only on clr_overrun; a set in the same cycle wins over a clear.
- Pop: read_entry while queue_empty is ignored. A simultaneous push and pop leaves num_entries unchanged.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. num_entries = wr_ptr - rd_ptr.
- Latency: the head outputs are combinational from the read pointer. num_entries increments in the cycle after the final stop sample.
- Parity is not checked when parity_en = 0; the parity_err field stores 0.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - the constants MIN_DATA_BITS = 5 and MAX_STOP_BITS = 2.
- Sub-module uart_rx_fifo: a parametrised circular queue (width MAX_DATA_BITS+2, depth FIFO_DEPTH). It owns the pointers and the full/empty/count logic and exposes push, pop, accept and head data.

Test Plan:
- 8N1, baud_reload=15, send 0xA5 -> one entry; rx_data=0xA5, both error bits 0, num_entries=1; read_entry -> queue_empty=1.
- 7E1 (data_bits=7, parity_en=1, parity_odd=0), send 0x41 with parity bit 1 -> rx_data=0x41, rx_parity_err=1.
- 8N2, second stop bit driven 0, data 0x3C -> rx_data=0x3C, rx_frame_err=1.
- RX low pulse of 4 clocks with baud_reload=15 -> false start; queue stays empty and the FSM is in IDLE.
- FIFO_DEPTH=4, send 5 characters with no reads -> queue_full=1, num_entries=4, overrun=1, first 4 characters intact. Then clr_overrun -> overrun=0.
- Assert rst during the DATA state of frame 0x55, release, then send 0x12 -> only 0x12 is queued.
